// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: stream field widths, stored-entry layout and write-FSM states for the RX packet FIFO
package eth_rx_pkg;
   localparam int DATA_W  = 64;
   localparam int MOD_W   = 3;
   localparam int FLAGS_W = 4;
   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [MOD_W-1:0]   mod;
      logic [FLAGS_W-1:0] flags;
   } t_entry;
   localparam int ENTRY_W = $bits(t_entry);
   typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} t_wr_state;
endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// eth_pkt_fifo_ram: simple dual-port beat store with registered read, array not reset
module eth_pkt_fifo_ram
   import eth_rx_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [AW-1:0]      i_waddr,
   input  logic [ENTRY_W-1:0] i_wdata,
   input  logic               i_re,
   input  logic [AW-1:0]      i_raddr,
   output logic [ENTRY_W-1:0] o_rdata
);
   logic [ENTRY_W-1:0] r_mem [DEPTH];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/eth_rx_pkt_fifo.sv
// eth_rx_pkt_fifo: store-and-forward RX frame FIFO; frames become readable only once committed at eop,
// bad/overflowing frames are rewound away, and a 2-entry skid buffer sustains 1 beat/cycle out.
module eth_rx_pkt_fifo
   import eth_rx_pkg::*;
#(
   parameter int DEPTH        = 512,
   parameter bit DROP_ON_ERR  = 1'b1,
   parameter int ERR_FLAG_BIT = 0
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic [DATA_W-1:0]        i_in_data,
   input  logic                     i_in_sop,
   input  logic                     i_in_eop,
   input  logic [MOD_W-1:0]         i_in_mod,
   input  logic [FLAGS_W-1:0]       i_in_flags,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   output logic [DATA_W-1:0]        o_out_data,
   output logic                     o_out_sop,
   output logic                     o_out_eop,
   output logic [MOD_W-1:0]         o_out_mod,
   output logic [FLAGS_W-1:0]       o_out_flags,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic                     o_frame_avail,
   output logic [$clog2(DEPTH):0]   o_frame_cnt,
   output logic [15:0]              o_drop_cnt,
   output logic                     o_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   t_wr_state   r_state, w_state_nxt;
   logic [AW:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_frame_cnt;
   logic [AW:0] w_base, w_wr_nxt, w_commit_nxt;
   logic [15:0] r_drop_cnt;
   logic [16:0] w_drop_sum;
   logic [1:0]  r_sk_cnt, w_drop_inc, w_push_idx;
   logic [2:0]  w_room;
   logic        r_ready, r_ovf, r_inflight;
   logic        w_acc, w_restart, w_full, w_we, w_ovf, w_commit, w_pop, w_issue;
   t_entry      r_sk [2];
   t_entry      w_in, w_rd_data;

   assign w_in      = '{data: i_in_data, sop: i_in_sop, eop: i_in_eop, mod: i_in_mod, flags: i_in_flags};
   assign w_acc     = i_in_valid & r_ready;
   assign w_restart = i_in_sop & (r_state == WR_FRAME);
   // a sop inside a frame abandons the partial frame, so fullness is judged from the commit point
   assign w_base    = w_restart ? r_commit_ptr : r_wr_ptr;
   assign w_full    = (w_base - r_rd_ptr) == FULL_LVL;

   always_comb begin
      w_state_nxt  = r_state;
      w_wr_nxt     = r_wr_ptr;
      w_commit_nxt = r_commit_ptr;
      w_we         = 1'b0;
      w_ovf        = 1'b0;
      w_commit     = 1'b0;
      w_drop_inc   = 2'd0;
      if (w_acc) begin
         if (!i_in_sop && r_state != WR_FRAME) begin
            w_drop_inc  = {1'b0, r_state == WR_IDLE};
            w_state_nxt = i_in_eop ? WR_IDLE : r_state;
         end else if (w_full) begin
            w_wr_nxt    = r_commit_ptr;
            w_drop_inc  = 2'd1 + {1'b0, w_restart};
            w_ovf       = 1'b1;
            w_state_nxt = i_in_eop ? WR_IDLE : WR_DROP;
         end else if (DROP_ON_ERR && i_in_eop && i_in_flags[ERR_FLAG_BIT]) begin
            w_wr_nxt    = r_commit_ptr;
            w_drop_inc  = 2'd1 + {1'b0, w_restart};
            w_state_nxt = WR_IDLE;
         end else begin
            w_we         = 1'b1;
            w_wr_nxt     = w_base + PTR_ONE;
            w_drop_inc   = {1'b0, w_restart};
            w_state_nxt  = i_in_eop ? WR_IDLE : WR_FRAME;
            w_commit     = i_in_eop;
            w_commit_nxt = i_in_eop ? w_base + PTR_ONE : r_commit_ptr;
         end
      end
   end

   eth_pkt_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (w_base[AW-1:0]),
      .i_wdata (w_in),
      .i_re    (w_issue),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rd_data)
   );

   // skid occupancy counts the beat already in flight from the RAM
   assign w_pop      = (r_sk_cnt != 2'd0) & i_out_ready;
   assign w_room     = {1'b0, r_sk_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
   assign w_issue    = (r_rd_ptr != r_commit_ptr) && (w_room < 3'd2);
   assign w_push_idx = r_sk_cnt - {1'b0, w_pop};
   assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= WR_IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_rd_ptr     <= '0;
         r_frame_cnt  <= '0;
         r_drop_cnt   <= '0;
         r_sk_cnt     <= 2'd0;
         r_ready      <= 1'b0;
         r_ovf        <= 1'b0;
         r_inflight   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_ptr     <= w_wr_nxt;
         r_commit_ptr <= w_commit_nxt;
         r_rd_ptr     <= r_rd_ptr + {{AW{1'b0}}, w_issue};
         r_frame_cnt  <= r_frame_cnt + {{AW{1'b0}}, w_commit} - {{AW{1'b0}}, w_pop & r_sk[0].eop};
         r_drop_cnt   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         r_sk_cnt     <= r_sk_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
         r_ready      <= 1'b1;
         r_ovf        <= w_ovf;
         r_inflight   <= w_issue;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_pop) r_sk[0] <= r_sk[1];
      if (r_inflight) r_sk[w_push_idx[0]] <= w_rd_data;
   end

   assign o_in_ready    = r_ready;
   assign o_out_valid   = r_sk_cnt != 2'd0;
   assign o_out_data    = r_sk[0].data;
   assign o_out_sop     = r_sk[0].sop;
   assign o_out_eop     = r_sk[0].eop;
   assign o_out_mod     = r_sk[0].mod;
   assign o_out_flags   = r_sk[0].flags;
   assign o_frame_cnt   = r_frame_cnt;
   assign o_frame_avail = r_frame_cnt != '0;
   assign o_drop_cnt    = r_drop_cnt;
   assign o_overflow    = r_ovf;
endmodule

// File: tb/tb_eth_rx_pkt_fifo.sv
// tb_eth_rx_pkt_fifo: two DEPTH=16 instances (drop-on-error on / off) checked every cycle against a frame-queue model
`timescale 1ns/1ps
module tb_eth_rx_pkt_fifo;
   localparam int DEPTH = 16;
   localparam int M_IDLE = 0, M_FRAME = 1, M_DROP = 2;
   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic [3:0]  flags;
   } t_beat;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [2:0]  in_mod = '0;
   logic [3:0]  in_flags = '0;
   logic [63:0] out_data [2];
   logic        out_sop [2], out_eop [2], out_valid [2], in_ready [2], frame_avail [2], overflow [2];
   logic [2:0]  out_mod [2];
   logic [3:0]  out_flags [2];
   logic [4:0]  frame_cnt [2];
   logic [15:0] drop_cnt [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      eth_rx_pkt_fifo #(.DEPTH(DEPTH), .DROP_ON_ERR(g == 0), .ERR_FLAG_BIT(0)) u_dut (
         .i_clk(clk), .i_reset_n(rst_n),
         .i_in_data(in_data), .i_in_sop(in_sop), .i_in_eop(in_eop), .i_in_mod(in_mod),
         .i_in_flags(in_flags), .i_in_valid(in_valid), .o_in_ready(in_ready[g]),
         .o_out_data(out_data[g]), .o_out_sop(out_sop[g]), .o_out_eop(out_eop[g]), .o_out_mod(out_mod[g]),
         .o_out_flags(out_flags[g]), .o_out_valid(out_valid[g]), .i_out_ready(out_ready),
         .o_frame_avail(frame_avail[g]), .o_frame_cnt(frame_cnt[g]), .o_drop_cnt(drop_cnt[g]),
         .o_overflow(overflow[g])
      );
   end

   always #5 clk = ~clk;

   t_beat part_q [2][$];
   t_beat com_q [2][$];
   int    mode [2] = '{M_IDLE, M_IDLE};
   int    exp_drop [2] = '{0, 0};
   int    exp_frames [2] = '{0, 0};
   int    n_out [2] = '{0, 0};
   bit    exp_ovf [2] = '{0, 0};
   bit    stall_prev [2] = '{0, 0};
   t_beat held [2];
   bit    exp_ready = 1'b0;
   int    total = 0, bad = 0, cyc = 0;
   int    commit_cyc = 0, first_valid_cyc = 0;
   bit    seen_valid = 1'b0;
   int    rdy_mode = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic t_beat dut_beat(input int d);
      return '{out_data[d], out_sop[d], out_eop[d], out_mod[d], out_flags[d]};
   endfunction

   // frame-level rules: whole frames appear on the output only once their eop is accepted
   task automatic model_beat(input int d, input t_beat b);
      if (!b.sop && mode[d] != M_FRAME) begin
         if (mode[d] == M_IDLE) exp_drop[d]++;
         else if (b.eop) mode[d] = M_IDLE;
      end else begin
         if (b.sop && mode[d] == M_FRAME) begin
            exp_drop[d]++;
            part_q[d].delete();
         end
         if (part_q[d].size() + com_q[d].size() >= DEPTH) begin
            exp_drop[d]++;
            exp_ovf[d] = 1'b1;
            part_q[d].delete();
            mode[d] = b.eop ? M_IDLE : M_DROP;
         end else if (b.eop) begin
            mode[d] = M_IDLE;
            if (d == 0 && b.flags[0]) begin
               exp_drop[d]++;
               part_q[d].delete();
            end else begin
               part_q[d].push_back(b);
               foreach (part_q[d][i]) com_q[d].push_back(part_q[d][i]);
               part_q[d].delete();
               exp_frames[d]++;
               if (d == 0) commit_cyc = cyc;
            end
         end else begin
            part_q[d].push_back(b);
            mode[d] = M_FRAME;
         end
      end
   endtask

   always @(negedge clk) begin
      t_beat cur;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("in_ready%0d", d), in_ready[d], exp_ready);
         chk($sformatf("drop_cnt%0d", d), drop_cnt[d], exp_drop[d]);
         chk($sformatf("frame_cnt%0d", d), frame_cnt[d], exp_frames[d]);
         chk($sformatf("frame_avail%0d", d), frame_avail[d], exp_frames[d] != 0);
         chk($sformatf("overflow%0d", d), overflow[d], exp_ovf[d]);
         if (stall_prev[d]) begin
            chk($sformatf("stall_valid%0d", d), out_valid[d], 1'b1);
            chk($sformatf("stall_data%0d", d), dut_beat(d), held[d]);
         end
      end
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            part_q[d].delete();
            com_q[d].delete();
            mode[d] = M_IDLE;
            exp_drop[d] = 0;
            exp_frames[d] = 0;
            exp_ovf[d] = 1'b0;
            stall_prev[d] = 1'b0;
         end
         exp_ready = 1'b0;
         seen_valid = 1'b0;
      end else begin
         cur = '{in_data, in_sop, in_eop, in_mod, in_flags};
         if (out_valid[0] && !seen_valid) begin
            seen_valid = 1'b1;
            first_valid_cyc = cyc;
         end
         for (int d = 0; d < 2; d++) begin
            stall_prev[d] = out_valid[d] && !out_ready;
            held[d] = dut_beat(d);
            if (out_valid[d] && out_ready) begin
               if (com_q[d].size() == 0) chk($sformatf("out_extra%0d", d), 1'b1, 1'b0);
               else begin
                  chk($sformatf("out_beat%0d", d), dut_beat(d), com_q[d][0]);
                  if (com_q[d][0].eop) exp_frames[d]--;
                  void'(com_q[d].pop_front());
                  n_out[d]++;
               end
            end
            exp_ovf[d] = 1'b0;
            if (in_valid && exp_ready) model_beat(d, cur);
         end
         exp_ready = 1'b1;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'b0;
            default: out_ready = $urandom_range(0, 3) != 0;
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit sop, input bit eop, input logic [3:0] fl);
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_flags = fl;
      in_mod   = 3'($urandom);
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic frame(input int len, input bit err);
      for (int i = 0; i < len; i++)
         drive(i == 0, i == len - 1, (i == len - 1) ? {3'($urandom), err} : 4'($urandom));
   endtask

   task automatic drain();
      int n = 0;
      while ((com_q[0].size() != 0 || com_q[1].size() != 0) && n < 500) begin
         idle(1);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 1'b1, 1'b0);
      idle(3);
   endtask

   task automatic wait_room(input int need);
      int n = 0;
      while ((com_q[0].size() + part_q[0].size() + need > DEPTH - 2 ||
              com_q[1].size() + part_q[1].size() + need > DEPTH - 2) && n < 300) begin
         idle(1);
         n++;
      end
      if (n >= 300) chk("room_timeout", 1'b1, 1'b0);
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(2);
      // single 4-beat frame: first beat out three cycles after its eop
      frame(4, 1'b0);
      idle(6);
      chk("t1_latency", first_valid_cyc - commit_cyc, 3);
      drain();
      chk("t1_n_out", n_out[0], 4);
      chk("t1_drop", drop_cnt[0], 0);
      // 20-beat frame into 16 entries overflows on beat 17
      for (int i = 0; i < 20; i++) begin
         drive(i == 0, i == 19, 4'h0);
         if (i == 15) chk("t2_no_ovf_b16", overflow[0], 1'b0);
         if (i == 16) chk("t2_ovf_b17", overflow[0], 1'b1);
      end
      idle(4);
      chk("t2_drop", drop_cnt[0], 1);
      chk("t2_no_out", n_out[0], 4);
      frame(3, 1'b0);
      drain();
      chk("t2_n_out", n_out[0], 7);
      // errored eop: dropped only when DROP_ON_ERR=1
      frame(2, 1'b1);
      drain();
      chk("t3_drop_a", drop_cnt[0], 2);
      chk("t3_drop_b", drop_cnt[1], 1);
      chk("t3_n_out_b", n_out[1], 9);
      // missing eop, then stray beat in idle
      drive(1, 0, 4'h0); drive(0, 0, 4'h0); drive(1, 0, 4'h0); drive(0, 0, 4'h0); drive(0, 1, 4'h0);
      drain();
      chk("t4_drop_a", drop_cnt[0], 3);
      drive(0, 0, 4'h0);
      idle(2);
      chk("t4_stray_a", drop_cnt[0], 4);
      chk("t4_stray_b", drop_cnt[1], 3);
      chk("t4_n_out_a", n_out[0], 10);
      // back-to-back single-beat frames with toggling ready
      rdy_mode = 1;
      repeat (10) frame(1, 1'b0);
      drain();
      chk("t5_n_out_a", n_out[0], 20);
      chk("t5_n_out_b", n_out[1], 22);
      // reset with two frames stored and a third in progress
      rdy_mode = 2;
      frame(3, 1'b0);
      frame(3, 1'b0);
      drive(1, 0, 4'h0);
      drive(0, 0, 4'h0);
      idle(2);
      chk("t6_stored", frame_cnt[0], 2);
      rst_n = 1'b0;
      idle(1);
      chk("t6_valid", out_valid[0], 1'b0);
      chk("t6_frames", frame_cnt[0], 0);
      rst_n = 1'b1;
      rdy_mode = 0;
      idle(2);
      frame(4, 1'b0);
      drain();
      chk("t6_n_out_a", n_out[0], 24);
      chk("t6_drop", drop_cnt[0], 0);
      // randomized traffic with random output backpressure
      rdy_mode = 3;
      repeat (80) begin
         int kind, len;
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 6);
         wait_room(len + 1);
         if (kind == 0) drive(0, 1'($urandom), 4'($urandom));
         else if (kind == 1) for (int i = 0; i < $urandom_range(1, 3); i++) drive(i == 0, 0, 4'($urandom));
         else frame(len, kind == 2);
         idle($urandom_range(0, 2));
      end
      rdy_mode = 0;
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
